// File: rtl/count_seq_checker_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } chk_state_t;

  // Widest count bus the increment helper supports.
  localparam int unsigned CNT_MAX_W = 32;

  // Plain +1; callers truncate the result to their own width, which gives the
  // natural modulo wrap of an all-ones value to zero.
  function automatic logic [CNT_MAX_W-1:0] next_count(input logic [CNT_MAX_W-1:0] v);
    return v + {{(CNT_MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/count_seq_checker_sat.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next value: clear wins, otherwise count up until all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_seq_checker.sv
// Monitor for a free-running up-counter bus: locks onto the +1 sequence,
// pulses err on every break seen while locked and keeps error/wrap statistics.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err,
  output logic [WIDTH-1:0]  exp_count,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] wrap_cnt
);

  // good only has to reach LOCK_N, so it needs enough bits to hold that value.
  localparam int GOOD_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [GOOD_W-1:0] LOCK_N_G = GOOD_W'(LOCK_N);

  // WIDTH-bit increment built on the package helper.
  function automatic logic [WIDTH-1:0] inc_w(input logic [WIDTH-1:0] v);
    return WIDTH'(next_count(CNT_MAX_W'(v)));
  endfunction

  chk_state_t         state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   prev_inc;
  logic [GOOD_W-1:0]  good_inc;
  logic               hit;
  logic               err_inc;
  logic               wrap_inc;

  assign prev_inc = inc_w(prev_q);
  assign good_inc = good_q + {{(GOOD_W-1){1'b0}}, 1'b1};
  assign hit      = (count == prev_inc);

  // Next-state, sample capture and statistic increments; clr overrides en.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    good_d   = good_q;
    err_d    = 1'b0;
    err_inc  = 1'b0;
    wrap_inc = 1'b0;
    if (clr) begin
      state_d = IDLE;
      prev_d  = '0;
      good_d  = '0;
    end else if (en) begin
      prev_d = count;
      case (state_q)
        IDLE: begin
          good_d  = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (hit) begin
            good_d = good_inc;
            if (good_inc == LOCK_N_G) begin
              state_d = TRACK;
            end
          end else begin
            good_d = '0;
          end
        end
        TRACK: begin
          if (hit) begin
            if ((prev_q == {WIDTH{1'b1}}) && (count == '0)) begin
              wrap_inc = 1'b1;
            end
          end else begin
            // Break: report it and resynchronise to the observed value.
            err_d   = 1'b1;
            err_inc = 1'b1;
            good_d  = '0;
            state_d = ACQ;
          end
        end
        default: begin
          state_d = IDLE;
          prev_d  = '0;
          good_d  = '0;
        end
      endcase
    end
  end

  // State, previous sample, lock progress and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      good_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (err_inc),
    .q     (err_cnt)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (wrap_inc),
    .q     (wrap_cnt)
  );

  // All outputs decode registered state only.
  assign locked    = (state_q == TRACK);
  assign err       = err_q;
  assign exp_count = (state_q == IDLE) ? '0 : prev_inc;

endmodule
